// File: rtl/string_print_ctrl.sv
// Print-string sequencer: borrows the DATA_MEMORY port from the pipeline, walks
// string words downward in address and streams their bytes MSB-first until a NUL byte.
module string_print_ctrl #(
    parameter logic [31:0] MEM_LO    = 32'h7FF00000,
    parameter logic [31:0] MEM_HI    = 32'h7FFFFFFF,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] str_addr,
    input  logic        pipe_mem_write,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_write_data,
    output logic [31:0] pipe_read_data,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        stall,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        done,
    output logic        error
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      ptr;
    logic [31:0]      ptr_next;
    logic [31:0]      word;
    logic [31:0]      word_next;
    logic [1:0]       byte_idx;
    logic [1:0]       byte_idx_next;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_cnt_next;
    logic             err_flag;
    logic             err_flag_next;

    logic [7:0]       cur_byte;
    logic             range_bad;
    logic             limit_hit;

    always_comb begin
        case (byte_idx)
            2'd3:    cur_byte = word[31:24];
            2'd2:    cur_byte = word[23:16];
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
    end

    // A pointer that wrapped below zero lands above MEM_HI and aborts here.
    assign range_bad = (ptr < MEM_LO) || (ptr > MEM_HI);
    assign limit_hit = (word_cnt == CNT_W'(MAX_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            word     <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            word     <= word_next;
            byte_idx <= byte_idx_next;
            word_cnt <= word_cnt_next;
            err_flag <= err_flag_next;
        end
    end

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        word_next     = word;
        byte_idx_next = byte_idx;
        word_cnt_next = word_cnt;
        err_flag_next = err_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_next      = str_addr;
                    word_cnt_next = '0;
                    err_flag_next = 1'b0;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                if (range_bad || limit_hit) begin
                    err_flag_next = 1'b1;
                    state_next    = FINISH;
                end else begin
                    word_next     = mem_read_data;
                    byte_idx_next = 2'd3;
                    ptr_next      = ptr - 32'd1;
                    word_cnt_next = word_cnt + 1'b1;
                    state_next    = EMIT;
                end
            end
            EMIT: begin
                if (cur_byte == 8'h00) begin
                    state_next = FINISH;
                end else if (char_ready) begin
                    if (byte_idx == 2'd0) begin
                        state_next = FETCH;
                    end else begin
                        byte_idx_next = byte_idx - 2'd1;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The controller only ever reads; pipeline writes are blocked while it owns the port.
    always_comb begin
        stall          = (state != IDLE);
        mem_write      = 1'b0;
        mem_addr       = ptr;
        mem_write_data = '0;
        pipe_read_data = '0;
        if (state == IDLE) begin
            mem_write      = pipe_mem_write;
            mem_addr       = pipe_addr;
            mem_write_data = pipe_write_data;
            pipe_read_data = mem_read_data;
        end
        char_valid = (state == EMIT) && (cur_byte != 8'h00);
        char_data  = char_valid ? cur_byte : 8'h00;
        done       = (state == FINISH);
        error      = (state == FINISH) && err_flag;
    end

endmodule
